multicycle_control: RTL

- Multi-cycle MIPS sequencing controller. Replaces the single-cycle opcode decoder in front of the shared datapath (ALU, register file, unified instruction/data memory).
- Steps each instruction through fetch, decode, execute, memory and writeback states. Asserts the per-state datapath strobes.
- Stalls on a memory ready handshake, traps illegal instructions and counts retired instructions.

---
 rtl/multicycle_control.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Multi-cycle MIPS sequencing controller. Steps each instruction
//             through fetch, decode, execute, memory and writeback states and
//             drives the shared datapath strobes for each state. It stalls on
//             mem_ready, traps illegal instructions and counts retired
//             instructions.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   system clock, rising edge
//    rst_n          in   asynchronous active-low reset
//    run            in   start/continue; sampled in IDLE and at instruction end
//    op[5:0]        in   opcode IR[31:26], valid from DECODE onward
//    funct[5:0]     in   funct field IR[5:0]
//    mem_ready      in   memory access completes this cycle
//    pc_write       out  unconditional PC load
//    pc_write_cond  out  PC load qualified by ALU zero (beq)
//    pc_src[1:0]    out  00 ALU result, 01 ALUOut, 10 jump target
//    iord           out  memory address select: 0 PC, 1 ALUOut
//    mem_read       out  memory read strobe
//    mem_write      out  memory write strobe
//    ir_write       out  instruction register load
//    reg_dest       out  write register select: 1 rd, 0 rt
//    mem_to_reg     out  writeback data select: 1 MDR, 0 ALUOut
//    reg_write      out  register file write enable
//    alu_src_a      out  0 PC, 1 rs
//    alu_src_b[1:0] out  00 rt, 01 const 4, 10 sext imm, 11 sext imm<<2
//    alu_ctrl[3:0]  out  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
//    state[3:0]     out  current state encoding (debug)
//    instr_done     out  one-cycle pulse when an instruction retires
//    instr_count    out  retired instruction count, wraps modulo 2^CNT_W
//    illegal_op     out  high while trapped
// ============================================================================
module multicycle_control #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic [1:0]       pc_src,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_dest,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [3:0]       alu_ctrl,
   output logic [3:0]       state,
   output logic             instr_done,
   output logic [CNT_W-1:0] instr_count,
   output logic             illegal_op
);

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type funct codes
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC_R   = 4'd7,
      S_RTYPE_WB = 4'd8,
      S_EXEC_I   = 4'd9,
      S_IMM_WB   = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12,
      S_TRAP     = 4'd15
   } state_t;

   state_t           cur_state;
   state_t           nxt_state;
   logic             funct_ok;
   logic [3:0]       funct_alu;
   logic             retire;

   // R-type funct decode: legality and the ALU operation it selects.
   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = ALU_ADD;
      case (funct)
         FN_ADD:  funct_alu = ALU_ADD;
         FN_SUB:  funct_alu = ALU_SUB;
         FN_AND:  funct_alu = ALU_AND;
         FN_OR:   funct_alu = ALU_OR;
         FN_SLT:  funct_alu = ALU_SLT;
         default: funct_ok  = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= S_IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // Next-state and per-state strobe decode. Strobes depend only on the
   // current state (plus mem_ready in FETCH/MEM_WR and funct in EXEC_R), so a
   // reset forces every strobe low without waiting for a clock edge.
   always_comb begin
      nxt_state     = cur_state;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 2'b00;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dest      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_ctrl      = 4'b0000;
      illegal_op    = 1'b0;
      retire        = 1'b0;

      case (cur_state)
         S_IDLE: begin
            if (run) nxt_state = S_FETCH;
         end

         S_FETCH: begin
            // PC+4 is computed every fetch cycle, but the IR and PC are only
            // loaded in the cycle the memory delivers the instruction.
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            alu_ctrl  = ALU_ADD;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready) nxt_state = S_DECODE;
         end

         S_DECODE: begin
            // Branch target precomputed speculatively into ALUOut.
            alu_src_b = 2'b11;
            alu_ctrl  = ALU_ADD;
            case (op)
               OP_RTYPE:     nxt_state = funct_ok ? S_EXEC_R : S_TRAP;
               OP_LW, OP_SW: nxt_state = S_MEM_ADDR;
               OP_ADDI:      nxt_state = S_EXEC_I;
               OP_BEQ:       nxt_state = S_BRANCH;
               OP_J:         nxt_state = S_JUMP;
               default:      nxt_state = S_TRAP;
            endcase
         end

         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_ctrl  = ALU_ADD;
            nxt_state = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
         end

         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) nxt_state = S_MEM_WB;
         end

         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            nxt_state  = run ? S_FETCH : S_IDLE;
         end

         S_MEM_WR: begin
            // The store only retires in the cycle memory accepts it.
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) begin
               retire    = 1'b1;
               nxt_state = run ? S_FETCH : S_IDLE;
            end
         end

         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b00;
            alu_ctrl  = funct_alu;
            nxt_state = S_RTYPE_WB;
         end

         S_RTYPE_WB: begin
            reg_write = 1'b1;
            reg_dest  = 1'b1;
            retire    = 1'b1;
            nxt_state = run ? S_FETCH : S_IDLE;
         end

         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_ctrl  = ALU_ADD;
            nxt_state = S_IMM_WB;
         end

         S_IMM_WB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            nxt_state = run ? S_FETCH : S_IDLE;
         end

         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_src_b     = 2'b00;
            alu_ctrl      = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_src        = 2'b01;
            retire        = 1'b1;
            nxt_state     = run ? S_FETCH : S_IDLE;
         end

         S_JUMP: begin
            pc_write  = 1'b1;
            pc_src    = 2'b10;
            retire    = 1'b1;
            nxt_state = run ? S_FETCH : S_IDLE;
         end

         S_TRAP: begin
            // Absorbing: only reset leaves the trap.
            illegal_op = 1'b1;
         end

         default: begin
            // Unused encodings 13 and 14 recover to IDLE.
            nxt_state = S_IDLE;
         end
      endcase
   end

   // Retired-instruction counter; wraps silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_count <= '0;
      end else if (retire) begin
         instr_count <= instr_count + 1'b1;
      end
   end

   assign instr_done = retire;
   assign state      = cur_state;

endmodule
`default_nettype wire
